// File: rtl/dual_fetch_sequencer_pkg.sv
// dual_fetch_sequencer_pkg: shared fetch-sequencer types and constants
package dual_fetch_sequencer_pkg;
  localparam int PC_W = 32;
  localparam int INSTR_BYTES = 4;
  localparam int PAIR_STRIDE = 8;
  typedef enum logic {PAIR, REWIND} fetch_state_t;
endpackage

// File: rtl/dual_fetch_sequencer_sat_counter.sv
// sat_counter: synchronous-reset up counter that sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = rst ? '0 : (inc && !(&count_q)) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk) count_q <= count_d;
  assign count = count_q;
endmodule

// File: rtl/dual_fetch_sequencer.sv
// dual_fetch_sequencer: dual-issue fetch PC sequencer with split rewind, split counter and sequencing error flag
module dual_fetch_sequencer
  import dual_fetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               StallPipeline2,
  input  logic               StallPipeline1NC,
  input  logic               StallF,
  input  logic               PCSrcE,
  input  logic [31:0]        PCTargetE,
  input  logic [31:0]        PCD2,
  output logic [31:0]        PCF1,
  output logic [31:0]        PCF2,
  output logic               FlushD,
  output logic               KillD2,
  output logic               SeqError,
  output logic [COUNT_W-1:0] SplitCount
);
  logic [PC_W-1:0] pc_q, pc_d;
  logic dvalid_q, dvalid_d, seq_error_q, seq_error_d, split_fire;
  fetch_state_t state_q, state_d;
  always_comb begin
    split_fire = state_q == PAIR && dvalid_q && StallPipeline2 && !PCSrcE && !StallF && !rst;
    pc_d = rst ? RESET_PC : PCSrcE ? PCTargetE : StallF ? pc_q : split_fire ? PCD2 : pc_q + PC_W'(PAIR_STRIDE);
    dvalid_d = (rst || PCSrcE || split_fire) ? 1'b0 : StallF ? dvalid_q : 1'b1;
    state_d = split_fire ? REWIND : PAIR;
    seq_error_d = !rst && (seq_error_q || (state_q == REWIND && !StallPipeline1NC));
    FlushD = rst || PCSrcE || split_fire;
    KillD2 = split_fire;
  end
  always_ff @(posedge clk) begin
    pc_q <= pc_d;
    dvalid_q <= dvalid_d;
    state_q <= state_d;
    seq_error_q <= seq_error_d;
  end
  sat_counter #(.W(COUNT_W)) u_split_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (split_fire),
    .count(SplitCount)
  );
  assign PCF1 = pc_q;
  assign PCF2 = pc_q + PC_W'(INSTR_BYTES);
  assign SeqError = seq_error_q;
endmodule
